// File: rtl/izh_synapse_accumulator.sv
// Synaptic current accumulator for the Izhikevich neuron: rising-edge
// weighted spike summation with exponential decay and saturation.
module izh_synapse_accumulator #(
  parameter int V_WIDTH   = 20,
  parameter int FR_WIDTH  = 11,
  parameter int N_IN      = 4,
  parameter int TAU_SHIFT = 3,
  parameter logic signed [V_WIDTH-1:0] WEIGHT_INIT = '0,
  localparam int ADDR_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_IN-1:0]    spike_in,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [V_WIDTH-1:0] wr_data,
  input  logic [V_WIDTH-1:0] bias,
  output logic [V_WIDTH-1:0] i_out,
  output logic               sat_pulse
);

  localparam int SUM_W = V_WIDTH + $clog2(N_IN) + 2;

  localparam logic signed [SUM_W-1:0] MAXV =
    {{(SUM_W-V_WIDTH+1){1'b0}}, {(V_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] MINV =
    {{(SUM_W-V_WIDTH+1){1'b1}}, {(V_WIDTH-1){1'b0}}};

  if (N_IN < 1 || TAU_SHIFT < 1 || FR_WIDTH >= V_WIDTH) begin : g_bad_param
    $error("izh_synapse_accumulator: bad parameters");
  end

  logic signed [V_WIDTH-1:0] w [N_IN];
  logic        [N_IN-1:0]    spike_q;
  logic        [N_IN-1:0]    edge_v;
  logic signed [V_WIDTH-1:0] i_q;
  logic signed [V_WIDTH-1:0] i_d;
  logic signed [V_WIDTH-1:0] step;
  logic signed [V_WIDTH-1:0] sbias;
  logic signed [SUM_W-1:0]   nxt;
  logic                      sat;

  assign sbias  = bias;
  assign edge_v = spike_in & ~spike_q;
  assign i_out  = i_q;

  always_comb begin
    step = i_q >>> TAU_SHIFT;
    // positive residue must still drain to exactly zero
    if (step == '0 && i_q > 0) begin
      step = V_WIDTH'(1);
    end
    nxt = SUM_W'(i_q) - SUM_W'(step) + SUM_W'(sbias);
    for (int k = 0; k < N_IN; k++) begin
      if (edge_v[k]) begin
        nxt = nxt + SUM_W'(w[k]);
      end
    end
  end

  always_comb begin
    sat = 1'b0;
    i_d = nxt[V_WIDTH-1:0];
    if (nxt > MAXV) begin
      sat = 1'b1;
      i_d = MAXV[V_WIDTH-1:0];
    end else if (nxt < MINV) begin
      sat = 1'b1;
      i_d = MINV[V_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_q       <= '0;
      sat_pulse <= 1'b0;
      spike_q   <= '0;
    end else begin
      i_q       <= i_d;
      sat_pulse <= sat;
      spike_q   <= spike_in;
    end
  end

  // edge in the write cycle sees the old weight via nonblocking update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_IN; k++) begin
        w[k] <= WEIGHT_INIT;
      end
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        if (wr_en && wr_addr == ADDR_W'(k)) begin
          w[k] <= wr_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_izh_synapse_accumulator.sv
// Scoreboard bench for izh_synapse_accumulator: reference model plus
// fixed-value checks of decay, saturation and write collision.
module tb_izh_synapse_accumulator;

  localparam int VW = 20;
  localparam int NI = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NI-1:0] spike_in = '0;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_addr = '0;
  logic [VW-1:0] wr_data = '0;
  logic [VW-1:0] bias = '0;
  logic [VW-1:0] i_out;
  logic          sat_pulse;

  izh_synapse_accumulator dut (
    .clk       (clk),
    .reset     (reset),
    .spike_in  (spike_in),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .bias      (bias),
    .i_out     (i_out),
    .sat_pulse (sat_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int i;
    int sat;
  } exp_t;

  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;

  int m_i;
  int m_w [NI];
  logic [NI-1:0] m_sq;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cur_i();
    return $signed(i_out);
  endfunction

  task automatic model_reset();
    m_i  = 0;
    m_sq = '0;
    for (int k = 0; k < NI; k++) m_w[k] = 0;
    q.delete();
  endtask

  // inputs are already driven; predict, clock, then compare
  task automatic tick();
    int s;
    int n;
    exp_t e;
    s = m_i >>> 3;
    if (s == 0 && m_i > 0) s = 1;
    n = m_i - s + $signed(bias);
    for (int k = 0; k < NI; k++)
      if (spike_in[k] && !m_sq[k]) n += m_w[k];
    e.sat = 0;
    if (n > 524287) begin
      n = 524287;
      e.sat = 1;
    end else if (n < -524288) begin
      n = -524288;
      e.sat = 1;
    end
    e.i = n;
    q.push_back(e);
    if (wr_en) m_w[wr_addr] = $signed(wr_data);
    m_sq = spike_in;
    m_i  = n;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = q.pop_front();
      chk("sb_i_out", cur_i(), e.i);
      chk("sb_sat", int'(sat_pulse), e.sat);
    end
  endtask

  task automatic ticks(input int n);
    for (int c = 0; c < n; c++) tick();
  endtask

  task automatic wr(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = 2'(a);
    wr_data = VW'(d);
    tick();
    wr_en = 1'b0;
  endtask

  int seq_p [10] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
  int seq_n [9]  = '{-9, -7, -6, -5, -4, -3, -2, -1, 0};

  initial begin
    model_reset();
    #12;
    chk("rst_i_out", cur_i(), 0);
    chk("rst_sat", int'(sat_pulse), 0);
    @(negedge clk);
    reset = 1'b0;
    #4;

    // reach 5000, then reset mid-run
    wr(0, 5000);
    spike_in = 4'b0001;
    tick();
    chk("t1_pre_i", cur_i(), 5000);
    spike_in = '0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("t1_async_i", cur_i(), 0);
    chk("t1_async_sat", int'(sat_pulse), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    spike_in = 4'b0001;
    tick();
    chk("t1_winit", cur_i(), 0);
    spike_in = '0;
    tick();

    // single spike held 8 cycles
    wr(0, 20480);
    spike_in = 4'b0001;
    tick();
    chk("t2_c0", cur_i(), 20480);
    tick();
    chk("t2_c1", cur_i(), 17920);
    tick();
    chk("t2_c2", cur_i(), 15680);
    ticks(5);
    spike_in = '0;
    ticks(150);
    chk("t2_zero", cur_i(), 0);

    // simultaneous edges
    for (int k = 1; k < NI; k++) wr(k, 20480);
    ticks(150);
    spike_in = 4'hf;
    tick();
    chk("t3_sum", cur_i(), 81920);
    chk("t3_sat", int'(sat_pulse), 0);
    spike_in = '0;
    ticks(150);

    // saturation both ways
    for (int k = 0; k < NI; k++) wr(k, 409600);
    ticks(150);
    spike_in = 4'hf;
    tick();
    chk("t4_pos_i", cur_i(), 524287);
    chk("t4_pos_sat", int'(sat_pulse), 1);
    tick();
    chk("t4_pos_sat_clr", int'(sat_pulse), 0);
    spike_in = '0;
    for (int k = 0; k < NI; k++) wr(k, -409600);
    ticks(200);
    spike_in = 4'hf;
    tick();
    chk("t4_neg_i", cur_i(), -524288);
    chk("t4_neg_sat", int'(sat_pulse), 1);
    spike_in = '0;
    ticks(200);

    // residue decays to exactly zero
    wr(0, 9);
    ticks(20);
    spike_in = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      tick();
      spike_in = '0;
      chk("t5_pos_seq", cur_i(), seq_p[c]);
    end
    ticks(3);
    chk("t5_pos_hold", cur_i(), 0);
    wr(0, -9);
    spike_in = 4'b0001;
    for (int c = 0; c < 9; c++) begin
      tick();
      spike_in = '0;
      chk("t5_neg_seq", cur_i(), seq_n[c]);
    end
    ticks(3);
    chk("t5_neg_hold", cur_i(), 0);

    // write collides with edge on same input
    wr(1, 1000);
    ticks(5);
    spike_in = 4'b0010;
    wr(1, 3000);
    chk("t6_old_w", cur_i(), 1000);
    spike_in = '0;
    ticks(150);
    spike_in = 4'b0010;
    tick();
    chk("t6_new_w", cur_i(), 3000);
    spike_in = '0;
    ticks(150);

    // tonic bias with random spikes
    bias = VW'(16);
    ticks(20);
    for (int c = 0; c < 60; c++) begin
      spike_in = NI'($urandom_range(0, 15));
      tick();
    end
    spike_in = '0;
    bias = '0;
    ticks(200);
    chk("end_zero", cur_i(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
